// File: rtl/ex5_ex6_if.sv
// Vote lines and the two population-count results, with the registered count and the sticky disagreement flag.
interface ex5_ex6_if;
  logic [6:0] t;
  logic [2:0] outswitch;
  logic [2:0] outassign;
  logic [2:0] count_q;
  logic       mismatch;

  modport master (
    output t,
    input  outswitch,
    input  outassign,
    input  count_q,
    input  mismatch
  );

  modport slave (
    input  t,
    output outswitch,
    output outassign,
    output count_q,
    output mismatch
  );
endinterface

// File: rtl/ex5_ex6.sv
// 7-bit population count built twice (case decoder and adder tree); comb outputs have zero latency, count_q has 1 cycle.
// No backpressure: t is sampled on every clk edge and mismatch latches any disagreement until rst.
module ex5_ex6 #(
  parameter int N_IN = 7
) (
  input  logic      clk,
  input  logic      rst,
  ex5_ex6_if.slave  bus
);

  logic [N_IN-1:0] tv;
  logic [2:0]      sw;
  logic            s1, c1, s2, c2, s0, c0;
  logic [2:0]      sum;

  assign tv = bus.t;

  // Row r covers t = 8r..8r+7; each entry is popcount(r) plus popcount(t[2:0]).
  always_comb begin
    sw = 3'd0;
    case (tv)
      7'h00: sw = 3'd0; 7'h01: sw = 3'd1; 7'h02: sw = 3'd1; 7'h03: sw = 3'd2; 7'h04: sw = 3'd1; 7'h05: sw = 3'd2; 7'h06: sw = 3'd2; 7'h07: sw = 3'd3;
      7'h08: sw = 3'd1; 7'h09: sw = 3'd2; 7'h0A: sw = 3'd2; 7'h0B: sw = 3'd3; 7'h0C: sw = 3'd2; 7'h0D: sw = 3'd3; 7'h0E: sw = 3'd3; 7'h0F: sw = 3'd4;
      7'h10: sw = 3'd1; 7'h11: sw = 3'd2; 7'h12: sw = 3'd2; 7'h13: sw = 3'd3; 7'h14: sw = 3'd2; 7'h15: sw = 3'd3; 7'h16: sw = 3'd3; 7'h17: sw = 3'd4;
      7'h18: sw = 3'd2; 7'h19: sw = 3'd3; 7'h1A: sw = 3'd3; 7'h1B: sw = 3'd4; 7'h1C: sw = 3'd3; 7'h1D: sw = 3'd4; 7'h1E: sw = 3'd4; 7'h1F: sw = 3'd5;
      7'h20: sw = 3'd1; 7'h21: sw = 3'd2; 7'h22: sw = 3'd2; 7'h23: sw = 3'd3; 7'h24: sw = 3'd2; 7'h25: sw = 3'd3; 7'h26: sw = 3'd3; 7'h27: sw = 3'd4;
      7'h28: sw = 3'd2; 7'h29: sw = 3'd3; 7'h2A: sw = 3'd3; 7'h2B: sw = 3'd4; 7'h2C: sw = 3'd3; 7'h2D: sw = 3'd4; 7'h2E: sw = 3'd4; 7'h2F: sw = 3'd5;
      7'h30: sw = 3'd2; 7'h31: sw = 3'd3; 7'h32: sw = 3'd3; 7'h33: sw = 3'd4; 7'h34: sw = 3'd3; 7'h35: sw = 3'd4; 7'h36: sw = 3'd4; 7'h37: sw = 3'd5;
      7'h38: sw = 3'd3; 7'h39: sw = 3'd4; 7'h3A: sw = 3'd4; 7'h3B: sw = 3'd5; 7'h3C: sw = 3'd4; 7'h3D: sw = 3'd5; 7'h3E: sw = 3'd5; 7'h3F: sw = 3'd6;
      7'h40: sw = 3'd1; 7'h41: sw = 3'd2; 7'h42: sw = 3'd2; 7'h43: sw = 3'd3; 7'h44: sw = 3'd2; 7'h45: sw = 3'd3; 7'h46: sw = 3'd3; 7'h47: sw = 3'd4;
      7'h48: sw = 3'd2; 7'h49: sw = 3'd3; 7'h4A: sw = 3'd3; 7'h4B: sw = 3'd4; 7'h4C: sw = 3'd3; 7'h4D: sw = 3'd4; 7'h4E: sw = 3'd4; 7'h4F: sw = 3'd5;
      7'h50: sw = 3'd2; 7'h51: sw = 3'd3; 7'h52: sw = 3'd3; 7'h53: sw = 3'd4; 7'h54: sw = 3'd3; 7'h55: sw = 3'd4; 7'h56: sw = 3'd4; 7'h57: sw = 3'd5;
      7'h58: sw = 3'd3; 7'h59: sw = 3'd4; 7'h5A: sw = 3'd4; 7'h5B: sw = 3'd5; 7'h5C: sw = 3'd4; 7'h5D: sw = 3'd5; 7'h5E: sw = 3'd5; 7'h5F: sw = 3'd6;
      7'h60: sw = 3'd2; 7'h61: sw = 3'd3; 7'h62: sw = 3'd3; 7'h63: sw = 3'd4; 7'h64: sw = 3'd3; 7'h65: sw = 3'd4; 7'h66: sw = 3'd4; 7'h67: sw = 3'd5;
      7'h68: sw = 3'd3; 7'h69: sw = 3'd4; 7'h6A: sw = 3'd4; 7'h6B: sw = 3'd5; 7'h6C: sw = 3'd4; 7'h6D: sw = 3'd5; 7'h6E: sw = 3'd5; 7'h6F: sw = 3'd6;
      7'h70: sw = 3'd3; 7'h71: sw = 3'd4; 7'h72: sw = 3'd4; 7'h73: sw = 3'd5; 7'h74: sw = 3'd4; 7'h75: sw = 3'd5; 7'h76: sw = 3'd5; 7'h77: sw = 3'd6;
      7'h78: sw = 3'd4; 7'h79: sw = 3'd5; 7'h7A: sw = 3'd5; 7'h7B: sw = 3'd6; 7'h7C: sw = 3'd5; 7'h7D: sw = 3'd6; 7'h7E: sw = 3'd6; 7'h7F: sw = 3'd7;
      default: sw = 3'd0;
    endcase
  end

  assign bus.outswitch = sw;

  // Two full adders compress the low and middle triplets; a third folds in t[6] at weight 1.
  assign s1 = tv[0] ^ tv[1] ^ tv[2];
  assign c1 = (tv[0] & tv[1]) | (tv[0] & tv[2]) | (tv[1] & tv[2]);
  assign s2 = tv[3] ^ tv[4] ^ tv[5];
  assign c2 = (tv[3] & tv[4]) | (tv[3] & tv[5]) | (tv[4] & tv[5]);
  assign s0 = s1 ^ s2 ^ tv[6];
  assign c0 = (s1 & s2) | (s1 & tv[6]) | (s2 & tv[6]);

  // The three weight-2 carries combine into bits 1 and 2.
  assign sum[0] = s0;
  assign sum[1] = c1 ^ c2 ^ c0;
  assign sum[2] = (c1 & c2) | (c1 & c0) | (c2 & c0);

  assign bus.outassign = sum;

  // Compares the driven outputs, so any disagreement seen on the bus is latched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.count_q  <= 3'd0;
      bus.mismatch <= 1'b0;
    end else begin
      bus.count_q <= bus.outassign;
      if (bus.outswitch != bus.outassign)
        bus.mismatch <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ex5_ex6.sv
// Randomized and directed checks of both popcount paths, the registered count and the sticky flag.
module tb_ex5_ex6;
  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;
  logic [6:0] cur_t;
  logic       exp_mm;

  ex5_ex6_if bus ();

  ex5_ex6 #(.N_IN(7)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] ones(input logic [6:0] v);
    int n;
    n = 0;
    for (int i = 0; i < 7; i++)
      if (v[i]) n++;
    return 8'(n);
  endfunction

  // Change t between edges, check comb outputs and that count_q still holds the old count, then check after the edge.
  task automatic apply(input logic [6:0] v, input string tag);
    logic [6:0] old;
    @(negedge clk);
    old   = cur_t;
    cur_t = v;
    bus.t = v;
    #1;
    check({tag, "/outswitch"}, {5'd0, bus.outswitch}, ones(v));
    check({tag, "/outassign"}, {5'd0, bus.outassign}, ones(v));
    check({tag, "/count_q_hold"}, {5'd0, bus.count_q}, ones(old));
    @(posedge clk);
    #1;
    check({tag, "/count_q"}, {5'd0, bus.count_q}, ones(v));
    check({tag, "/mismatch"}, {7'd0, bus.mismatch}, {7'd0, exp_mm});
  endtask

  initial begin
    int order [7];
    logic [6:0] v;
    order = '{0, 5, 1, 3, 2, 6, 4};
    n_tests = 0;
    n_fail  = 0;
    exp_mm  = 1'b0;
    cur_t   = 7'h00;
    rst     = 1'b1;
    bus.t   = 7'h00;

    #12;
    check("rst/count_q", {5'd0, bus.count_q}, 8'd0);
    check("rst/mismatch", {7'd0, bus.mismatch}, 8'd0);
    check("rst/outswitch", {5'd0, bus.outswitch}, 8'd0);
    check("rst/outassign", {5'd0, bus.outassign}, 8'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("release/count_q", {5'd0, bus.count_q}, 8'd0);

    v = 7'h00;
    for (int i = 0; i < 7; i++) begin
      v[order[i]] = 1'b1;
      apply(v, "set");
      repeat (18) @(posedge clk);
    end
    for (int i = 0; i < 7; i++) begin
      v[order[i]] = 1'b0;
      apply(v, "clr");
      repeat (18) @(posedge clk);
    end

    for (int i = 0; i < 128; i++)
      apply(7'(i), "sweep");
    check("sweep/mismatch_end", {7'd0, bus.mismatch}, 8'd0);

    for (int i = 0; i < 200; i++)
      apply(7'($urandom_range(127)), "rand");

    // Asynchronous reset between edges with all lines high.
    apply(7'h7F, "full");
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("midrst/count_q", {5'd0, bus.count_q}, 8'd0);
    check("midrst/mismatch", {7'd0, bus.mismatch}, 8'd0);
    check("midrst/outswitch", {5'd0, bus.outswitch}, 8'd7);
    check("midrst/outassign", {5'd0, bus.outassign}, 8'd7);
    @(posedge clk);
    #1;
    check("midrst/count_q_held", {5'd0, bus.count_q}, 8'd0);
    @(negedge clk);
    bus.t = 7'h15;
    cur_t = 7'h15;
    #1;
    check("inrst/outswitch", {5'd0, bus.outswitch}, ones(7'h15));
    check("inrst/outassign", {5'd0, bus.outassign}, ones(7'h15));
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("postrst/count_q_pre", {5'd0, bus.count_q}, 8'd0);
    @(posedge clk);
    #1;
    check("postrst/count_q", {5'd0, bus.count_q}, ones(7'h15));

    // Inject a wrong decoder result for one cycle.
    @(negedge clk);
    force bus.outswitch = 3'd6;
    @(posedge clk);
    #1;
    check("force/mismatch", {7'd0, bus.mismatch}, 8'd1);
    @(negedge clk);
    release bus.outswitch;
    #1;
    check("force/restored", {5'd0, bus.outswitch}, ones(cur_t));
    exp_mm = 1'b1;
    for (int i = 0; i < 10; i++)
      apply(7'($urandom_range(127)), "sticky");
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("clear/mismatch", {7'd0, bus.mismatch}, 8'd0);
    check("clear/count_q", {5'd0, bus.count_q}, 8'd0);
    @(negedge clk);
    rst = 1'b0;
    exp_mm = 1'b0;
    apply(7'h2A, "after");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
